vga_lt24_edge_irq_pio: RTL and testbench

//  Parametrised Avalon-MM input PIO with per-channel edge capture and IRQ, successor of the single-bit touch-pen IRQ port.

---
 rtl/vga_lt24_edge_irq_pio.sv | 194 +++++++++++++++++++
 tb/tb_vga_lt24_edge_irq_pio.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_lt24_edge_irq_pio.sv
// ---------------------------------------------------------------------------
// vga_lt24_edge_irq_pio
//
// Avalon-MM input PIO that captures edges on each channel and raises an
// interrupt. It sits between the LT24 / accelerometer interrupt pins and the
// Nios II IRQ line. Each channel is synchronised, then debounced, then
// edge-detected. Rising and falling capture are enabled separately. Captured
// edges stay latched in EDGE_CAP until software clears them by writing 1s.
//
// Ports
//   clk         system clock, all logic on the rising edge
//   reset       synchronous, active-high reset
//   address     Avalon word address (3 bits)
//   chipselect  Avalon select
//   write_n     Avalon write strobe, active low
//   writedata   Avalon write data (32 bits)
//   readdata    Avalon read data, registered, one cycle after the address
//   in_port     asynchronous input pins (WIDTH bits)
//   irq         interrupt request, active high
//
// Register map (word addresses; unused bits read 0)
//   0 DATA      RO   debounced input value
//   1 RISE_EN   RW   rising-edge capture enable
//   2 IRQ_MASK  RW   per-channel interrupt enable
//   3 EDGE_CAP  W1C  captured edges
//   4 FALL_EN   RW   falling-edge capture enable
//   5 DEBOUNCE  RW   debounce threshold in cycles (0 = bypass)
// ---------------------------------------------------------------------------
module vga_lt24_edge_irq_pio #(
  parameter int                WIDTH         = 8,
  parameter int                SYNC_STAGES   = 2,
  parameter int                DEB_W         = 16,
  parameter logic [WIDTH-1:0]  FALL_EN_RESET = {WIDTH{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_RISE_EN  = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_FALL_EN  = 3'd4;
  localparam logic [2:0] ADDR_DEBOUNCE = 3'd5;

  // Synchroniser chain; stage SYNC_STAGES-1 is the synchronised value.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]                  sync;

  // filt is the debounced value; filt_prev holds it delayed by one cycle
  // so edges can be found by comparing the two.
  logic [WIDTH-1:0]                  filt_q, filt_d;
  logic [WIDTH-1:0]                  filt_prev_q, filt_prev_d;
  logic [WIDTH-1:0][DEB_W-1:0]       cnt_q, cnt_d;

  logic [WIDTH-1:0]                  rise_en_q, rise_en_d;
  logic [WIDTH-1:0]                  irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0]                  edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0]                  fall_en_q, fall_en_d;
  logic [DEB_W-1:0]                  deb_q, deb_d;
  logic [31:0]                       readdata_q, readdata_d;

  logic                              wr;
  logic [WIDTH-1:0]                  wdata_ch;
  logic [WIDTH-1:0]                  clr;
  logic [WIDTH-1:0]                  rise;
  logic [WIDTH-1:0]                  fall;

  // Only the low WIDTH / DEB_W bits of writedata reach a register.
  logic                              unused_wdata;
  assign unused_wdata = ^writedata;

  assign wr       = chipselect & ~write_n;
  assign wdata_ch = writedata[WIDTH-1:0];
  assign sync     = sync_q[SYNC_STAGES-1];

  // Shift the pins through the synchroniser.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = in_port;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  // Debounce filter. A channel follows its synchronised input only after
  // the mismatch has lasted N consecutive cycles. A threshold of zero
  // bypasses the filter. Reprogramming the threshold restarts every count,
  // so a stale count from the old threshold is never compared against the
  // new one.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (deb_q == '0) begin
        filt_d[i] = sync[i];
      end else if (sync[i] != filt_q[i]) begin
        if (cnt_q[i] == deb_q - 1'b1) begin
          filt_d[i] = sync[i];
          cnt_d[i]  = '0;
        end else if (cnt_q[i] != {DEB_W{1'b1}}) begin
          cnt_d[i]  = cnt_q[i] + 1'b1;
        end else begin
          cnt_d[i]  = cnt_q[i];
        end
      end
      if (wr && address == ADDR_DEBOUNCE) begin
        cnt_d[i] = '0;
      end
    end
  end

  // Edge detection and capture. A new edge is ORed in after the clear, so
  // an edge arriving in the same cycle as a W1C of that bit is not lost.
  always_comb begin
    filt_prev_d = filt_q;
    rise        = filt_q & ~filt_prev_q & rise_en_q;
    fall        = ~filt_q & filt_prev_q & fall_en_q;
    clr         = '0;
    if (wr && address == ADDR_EDGE_CAP) begin
      clr = wdata_ch;
    end
    edge_cap_d  = (edge_cap_q & ~clr) | rise | fall;
  end

  // Control register writes.
  always_comb begin
    rise_en_d  = rise_en_q;
    irq_mask_d = irq_mask_q;
    fall_en_d  = fall_en_q;
    deb_d      = deb_q;
    if (wr) begin
      case (address)
        ADDR_RISE_EN:  rise_en_d  = wdata_ch;
        ADDR_IRQ_MASK: irq_mask_d = wdata_ch;
        ADDR_FALL_EN:  fall_en_d  = wdata_ch;
        ADDR_DEBOUNCE: deb_d      = writedata[DEB_W-1:0];
        default:       ;
      endcase
    end
  end

  // Read mux. It is registered every cycle whether or not the block is
  // selected, which gives a fixed one-cycle read latency.
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:     readdata_d[WIDTH-1:0] = filt_q;
      ADDR_RISE_EN:  readdata_d[WIDTH-1:0] = rise_en_q;
      ADDR_IRQ_MASK: readdata_d[WIDTH-1:0] = irq_mask_q;
      ADDR_EDGE_CAP: readdata_d[WIDTH-1:0] = edge_cap_q;
      ADDR_FALL_EN:  readdata_d[WIDTH-1:0] = fall_en_q;
      ADDR_DEBOUNCE: readdata_d[DEB_W-1:0] = deb_q;
      default:       readdata_d            = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q      <= '0;
      filt_q      <= '0;
      filt_prev_q <= '0;
      cnt_q       <= '0;
      rise_en_q   <= '0;
      irq_mask_q  <= '0;
      edge_cap_q  <= '0;
      fall_en_q   <= FALL_EN_RESET;
      deb_q       <= '0;
      readdata_q  <= '0;
    end else begin
      sync_q      <= sync_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_prev_d;
      cnt_q       <= cnt_d;
      rise_en_q   <= rise_en_d;
      irq_mask_q  <= irq_mask_d;
      edge_cap_q  <= edge_cap_d;
      fall_en_q   <= fall_en_d;
      deb_q       <= deb_d;
      readdata_q  <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_vga_lt24_edge_irq_pio.sv
// ---------------------------------------------------------------------------
// tb_vga_lt24_edge_irq_pio
//
// Directed testbench for vga_lt24_edge_irq_pio with the default parameters
// (WIDTH=8, SYNC_STAGES=2, DEB_W=16). Each step drives the bus or pins and
// then compares against a value worked out by hand.
// ---------------------------------------------------------------------------
module tb_vga_lt24_edge_irq_pio;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  in_port;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rd;
  logic [31:0] exp_rd [8];

  vga_lt24_edge_irq_pio dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One Avalon write; the register updates on the edge inside this task.
  task automatic applyStimulus(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  // Present an address, then return readdata from the following cycle.
  task automatic readReg(input logic [2:0] a, output logic [31:0] d);
    address = a;
    tick(1);
    d = readdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  initial begin
    reset      = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 8'h01;

    // Reset state.
    tick(2);
    checkOutput("reset_readdata", readdata, 32'h0);
    checkOutput("reset_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;
    tick(6);
    readReg(3'd4, rd); checkOutput("reset_fall_en", rd, 32'hFF);
    readReg(3'd1, rd); checkOutput("reset_rise_en", rd, 32'h0);
    // ch0 held high out of reset rises, but RISE_EN is clear.
    readReg(3'd3, rd); checkOutput("rise_not_captured", rd, 32'h0);
    readReg(3'd0, rd); checkOutput("data_ch0_high", rd, 32'h01);

    // 1: falling edge on ch0 is captured SYNC_STAGES+1 cycles after the
    // first sampling edge.
    applyStimulus(3'd2, 32'h1);
    in_port = 8'h00;
    tick(3);
    checkOutput("fall_not_yet", {31'b0, irq}, 32'h0);
    tick(1);
    checkOutput("fall_irq", {31'b0, irq}, 32'h1);
    readReg(3'd3, rd); checkOutput("fall_cap", rd, 32'h01);

    // 2: W1C in the same cycle as a new falling edge keeps the bit.
    in_port = 8'h01;
    tick(6);
    readReg(3'd3, rd); checkOutput("cap_held", rd, 32'h01);
    in_port = 8'h00;
    tick(3);
    applyStimulus(3'd3, 32'h1);
    checkOutput("edge_beats_clear_irq", {31'b0, irq}, 32'h1);
    readReg(3'd3, rd); checkOutput("edge_beats_clear", rd, 32'h01);
    applyStimulus(3'd3, 32'h1);
    checkOutput("clear_irq", {31'b0, irq}, 32'h0);
    readReg(3'd3, rd); checkOutput("clear_cap", rd, 32'h0);

    // 3: debounce threshold 4 on ch2.
    in_port = 8'h04;
    tick(6);
    applyStimulus(3'd5, 32'h4);
    readReg(3'd5, rd); checkOutput("deb_readback", rd, 32'h4);
    in_port = 8'h00;
    tick(3);
    in_port = 8'h04;
    tick(12);
    readReg(3'd0, rd); checkOutput("glitch3_data", rd, 32'h04);
    readReg(3'd3, rd); checkOutput("glitch3_cap", rd, 32'h0);
    in_port = 8'h00;
    tick(4);
    in_port = 8'h04;
    tick(12);
    readReg(3'd3, rd); checkOutput("pulse4_cap", rd, 32'h04);
    readReg(3'd0, rd); checkOutput("pulse4_data_back", rd, 32'h04);
    applyStimulus(3'd3, 32'hFF);
    in_port = 8'h00;
    tick(10);
    readReg(3'd0, rd); checkOutput("hold_low_data", rd, 32'h00);
    readReg(3'd3, rd); checkOutput("hold_low_cap", rd, 32'h04);
    checkOutput("masked_irq", {31'b0, irq}, 32'h0);

    // 4: rising-only capture on ch7 with the mask initially closed.
    applyStimulus(3'd5, 32'h0);
    applyStimulus(3'd3, 32'hFF);
    applyStimulus(3'd1, 32'h80);
    applyStimulus(3'd4, 32'h0);
    applyStimulus(3'd2, 32'h0);
    in_port = 8'h80;
    tick(3);
    in_port = 8'h00;
    tick(8);
    readReg(3'd3, rd); checkOutput("rise_only_cap", rd, 32'h80);
    checkOutput("mask_closed_irq", {31'b0, irq}, 32'h0);
    applyStimulus(3'd2, 32'h80);
    checkOutput("mask_open_irq", {31'b0, irq}, 32'h1);

    // 5: back-to-back reads, unmapped write ignored, unmapped reads 0.
    applyStimulus(3'd6, 32'hFFFF_FFFF);
    exp_rd[0] = 32'h00; exp_rd[1] = 32'h80; exp_rd[2] = 32'h80;
    exp_rd[3] = 32'h80; exp_rd[4] = 32'h00; exp_rd[5] = 32'h00;
    exp_rd[6] = 32'h00; exp_rd[7] = 32'h00;
    address = 3'd0;
    tick(1);
    for (int a = 1; a < 8; a++) begin
      checkOutput($sformatf("b2b_addr%0d", a - 1), readdata, exp_rd[a-1]);
      address = 3'(a);
      tick(1);
    end
    checkOutput("b2b_addr7", readdata, exp_rd[7]);

    // 6: reset in the middle of a debounce count with all edges captured.
    applyStimulus(3'd1, 32'hFFFF_FFFF);
    readReg(3'd1, rd); checkOutput("rise_en_width", rd, 32'hFF);
    applyStimulus(3'd4, 32'hFF);
    applyStimulus(3'd2, 32'hFF);
    in_port = 8'hFF;
    tick(6);
    readReg(3'd3, rd); checkOutput("all_cap", rd, 32'hFF);
    checkOutput("all_irq", {31'b0, irq}, 32'h1);
    applyStimulus(3'd5, 32'h8);
    in_port = 8'h00;
    tick(4);
    reset = 1'b1;
    tick(1);
    checkOutput("midreset_irq", {31'b0, irq}, 32'h0);
    checkOutput("midreset_readdata", readdata, 32'h0);
    reset = 1'b0;
    readReg(3'd0, rd); checkOutput("post_data", rd, 32'h0);
    readReg(3'd1, rd); checkOutput("post_rise_en", rd, 32'h0);
    readReg(3'd2, rd); checkOutput("post_mask", rd, 32'h0);
    readReg(3'd3, rd); checkOutput("post_cap", rd, 32'h0);
    readReg(3'd4, rd); checkOutput("post_fall_en", rd, 32'hFF);
    readReg(3'd5, rd); checkOutput("post_deb", rd, 32'h0);
    // Threshold back to 0 means the filter is bypassed again.
    in_port = 8'h01;
    tick(4);
    readReg(3'd0, rd); checkOutput("post_bypass_data", rd, 32'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
